// File: rtl/down_counter_timer_pkg.sv
// down_counter_timer_pkg: shared state encoding and default widths for the down counter timer.
package down_counter_timer_pkg;
   localparam int DEF_WIDTH = 4;
   localparam int DEF_PRESCALE_W = 4;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;
endpackage

// File: rtl/down_counter_timer_if.sv
// down_counter_timer_if: control, load and status signals of the down counter timer.
interface down_counter_timer_if
   import down_counter_timer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int PRESCALE_W = DEF_PRESCALE_W
) ();
   logic                  i_load;
   logic [WIDTH-1:0]      i_d_in;
   logic                  i_start;
   logic                  i_stop;
   logic                  i_auto_reload;
   logic [PRESCALE_W-1:0] i_prescale;
   logic [WIDTH-1:0]      o_d_out;
   logic                  o_tc;
   logic                  o_busy;
   modport master (
      output i_load, i_d_in, i_start, i_stop, i_auto_reload, i_prescale,
      input  o_d_out, o_tc, o_busy
   );
   modport slave (
      input  i_load, i_d_in, i_start, i_stop, i_auto_reload, i_prescale,
      output o_d_out, o_tc, o_busy
   );
endinterface

// File: rtl/down_counter_timer_prescaler_tick.sv
// prescaler_tick: counts enabled cycles and ticks when the count equals the live prescale value.
module prescaler_tick
   import down_counter_timer_pkg::*;
#(
   parameter int PRESCALE_W = DEF_PRESCALE_W
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_clr,
   input  logic                  i_en,
   input  logic [PRESCALE_W-1:0] i_prescale,
   output logic                  o_tick
);
   logic [PRESCALE_W-1:0] r_pre_cnt;
   // A prescale lowered below the running count is caught after the natural wrap.
   assign o_tick = i_en && (r_pre_cnt == i_prescale);
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_pre_cnt <= '0;
      else if (i_clr)
         r_pre_cnt <= '0;
      else if (i_en)
         r_pre_cnt <= o_tick ? '0 : r_pre_cnt + 1'b1;
   end
endmodule

// File: rtl/down_counter_timer.sv
// down_counter_timer: loadable prescaled down counter with terminal-count pulse and auto-reload.
module down_counter_timer
   import down_counter_timer_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int PRESCALE_W = DEF_PRESCALE_W
) (
   input logic                  clk,
   input logic                  rst,
   down_counter_timer_if.slave  io_bus
);
   state_t           r_state, w_state_nxt;
   logic [WIDTH-1:0] r_count, w_count_nxt;
   logic [WIDTH-1:0] r_reload, w_reload_nxt;
   logic             r_tc, w_tc_nxt;
   logic             w_en, w_tick;
   // load and stop take priority over a tick on the same edge, so the prescaler holds.
   assign w_en = (r_state == ST_RUN) && !io_bus.i_load && !io_bus.i_stop;
   prescaler_tick #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
      .clk        (clk),
      .rst        (rst),
      .i_clr      (io_bus.i_load),
      .i_en       (w_en),
      .i_prescale (io_bus.i_prescale),
      .o_tick     (w_tick)
   );
   always_comb begin
      w_state_nxt  = r_state;
      w_count_nxt  = r_count;
      w_reload_nxt = r_reload;
      w_tc_nxt     = 1'b0;
      if (io_bus.i_load) begin
         w_count_nxt  = io_bus.i_d_in;
         w_reload_nxt = io_bus.i_d_in;
         w_state_nxt  = ST_IDLE;
      end else if (io_bus.i_stop) begin
         w_state_nxt = (r_state == ST_RUN) ? ST_PAUSE : r_state;
      end else if (io_bus.i_start && r_state == ST_PAUSE) begin
         w_state_nxt = ST_RUN;
      end else if (io_bus.i_start && r_state == ST_IDLE) begin
         w_state_nxt = (r_count != '0) ? ST_RUN : ST_IDLE;
         w_tc_nxt    = (r_count == '0);
      end else if (w_tick && r_count > WIDTH'(1)) begin
         w_count_nxt = r_count - WIDTH'(1);
      end else if (w_tick && r_count == WIDTH'(1)) begin
         w_tc_nxt    = 1'b1;
         w_count_nxt = (io_bus.i_auto_reload && r_reload != '0) ? r_reload : '0;
         w_state_nxt = (io_bus.i_auto_reload && r_reload != '0) ? ST_RUN : ST_IDLE;
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= ST_IDLE;
         r_count  <= '0;
         r_reload <= '0;
         r_tc     <= 1'b0;
      end else begin
         r_state  <= w_state_nxt;
         r_count  <= w_count_nxt;
         r_reload <= w_reload_nxt;
         r_tc     <= w_tc_nxt;
      end
   end
   assign io_bus.o_d_out = r_count;
   assign io_bus.o_tc    = r_tc;
   assign io_bus.o_busy  = (r_state != ST_IDLE);
endmodule

// File: tb/tb_down_counter_timer.sv
// tb_down_counter_timer: vector table plus hand sequences, expected outputs queued per driven cycle.
module tb_down_counter_timer;
   logic clk;
   logic rst;
   int   tests = 0;
   int   fails = 0;
   down_counter_timer_if #(.WIDTH(4), .PRESCALE_W(4)) bus ();
   down_counter_timer #(.WIDTH(4), .PRESCALE_W(4)) dut (
      .clk    (clk),
      .rst    (rst),
      .io_bus (bus)
   );
   typedef struct {
      string      nm;
      logic [3:0] d;
      logic       tc;
      logic       busy;
   } exp_t;
   typedef struct {
      string      nm;
      logic       ld;
      logic [3:0] d_in;
      logic       st;
      logic       sp;
      logic       ar;
      logic [3:0] ps;
      logic [3:0] ed;
      logic       etc;
      logic       eb;
   } vec_t;
   exp_t q[$];
   vec_t tbl[$];
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end
   task automatic check(input string nm, input logic [3:0] d, input logic tc, input logic busy);
      tests++;
      if ({bus.o_d_out, bus.o_tc, bus.o_busy} !== {d, tc, busy}) begin
         fails++;
         $display("FAIL %s: got d_out=%0d tc=%0b busy=%0b, expected d_out=%0d tc=%0b busy=%0b",
                  nm, bus.o_d_out, bus.o_tc, bus.o_busy, d, tc, busy);
      end
   endtask
   task automatic step(input string nm, input logic ld, input logic [3:0] d_in, input logic st,
                       input logic sp, input logic ar, input logic [3:0] ps,
                       input logic [3:0] ed, input logic etc, input logic eb);
      exp_t e;
      @(negedge clk);
      bus.i_load = ld;
      bus.i_d_in = d_in;
      bus.i_start = st;
      bus.i_stop = sp;
      bus.i_auto_reload = ar;
      bus.i_prescale = ps;
      q.push_back('{nm, ed, etc, eb});
      @(posedge clk);
      #1;
      e = q.pop_front();
      check(e.nm, e.d, e.tc, e.busy);
   endtask
   initial begin
      rst = 1'b1;
      bus.i_load = 1'b0;
      bus.i_d_in = '0;
      bus.i_start = 1'b0;
      bus.i_stop = 1'b0;
      bus.i_auto_reload = 1'b0;
      bus.i_prescale = '0;
      #3;
      check("reset_state", 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      // prescale 0: one decrement per edge from 15 down to 0
      step("p0_load", 1, 15, 0, 0, 0, 0, 15, 0, 0);
      step("p0_start", 0, 0, 1, 0, 0, 0, 15, 0, 1);
      for (int i = 1; i <= 15; i++)
         step("p0_count", 0, 0, 0, 0, 0, 0, 4'(15 - i), i == 15, i < 15);
      step("p0_after", 0, 0, 0, 0, 0, 0, 0, 0, 0);
      // prescale 2: three cycles per step, tc nine edges after start
      step("p2_load", 1, 3, 0, 0, 0, 2, 3, 0, 0);
      step("p2_start", 0, 0, 1, 0, 0, 2, 3, 0, 1);
      for (int i = 1; i <= 9; i++)
         step("p2_count", 0, 0, 0, 0, 0, 2, 4'(3 - i / 3), i == 9, i < 9);
      tbl.push_back('{"ar_load",       1, 2, 0, 0, 1, 0, 2, 0, 0});
      tbl.push_back('{"ar_start",      0, 0, 1, 0, 1, 0, 2, 0, 1});
      tbl.push_back('{"ar_1",          0, 0, 0, 0, 1, 0, 1, 0, 1});
      tbl.push_back('{"ar_reload",     0, 0, 0, 0, 1, 0, 2, 1, 1});
      tbl.push_back('{"ar_1b",         0, 0, 0, 0, 1, 0, 1, 0, 1});
      tbl.push_back('{"ar_reload2",    0, 0, 0, 0, 1, 0, 2, 1, 1});
      tbl.push_back('{"ar_stop",       0, 0, 0, 1, 1, 0, 2, 0, 1});
      tbl.push_back('{"ar_paused",     0, 0, 0, 0, 1, 0, 2, 0, 1});
      tbl.push_back('{"ar_resume",     0, 0, 1, 0, 1, 0, 2, 0, 1});
      tbl.push_back('{"ar_resumed",    0, 0, 0, 0, 1, 0, 1, 0, 1});
      tbl.push_back('{"zero_load",     1, 0, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{"zero_start_tc", 0, 0, 1, 0, 0, 0, 0, 1, 0});
      tbl.push_back('{"zero_after",    0, 0, 0, 0, 0, 0, 0, 0, 0});
      tbl.push_back('{"load_and_start",1, 5, 1, 0, 0, 0, 5, 0, 0});
      tbl.push_back('{"ls_still_idle", 0, 0, 0, 0, 0, 0, 5, 0, 0});
      tbl.push_back('{"lt_load1",      1, 1, 0, 0, 0, 0, 1, 0, 0});
      tbl.push_back('{"lt_start",      0, 0, 1, 0, 0, 0, 1, 0, 1});
      tbl.push_back('{"load_on_tc",    1, 4, 0, 0, 0, 0, 4, 0, 0});
      tbl.push_back('{"stop_in_idle",  0, 0, 0, 1, 0, 0, 4, 0, 0});
      foreach (tbl[i])
         step(tbl[i].nm, tbl[i].ld, tbl[i].d_in, tbl[i].st, tbl[i].sp, tbl[i].ar, tbl[i].ps,
              tbl[i].ed, tbl[i].etc, tbl[i].eb);
      // prescale 1: pause with pre_cnt=1, so the first edge after resume must tick
      step("ps_load", 1, 9, 0, 0, 0, 1, 9, 0, 0);
      step("ps_start", 0, 0, 1, 0, 0, 1, 9, 0, 1);
      step("ps_c1", 0, 0, 0, 0, 0, 1, 9, 0, 1);
      step("ps_c2", 0, 0, 0, 0, 0, 1, 8, 0, 1);
      step("ps_c3", 0, 0, 0, 0, 0, 1, 8, 0, 1);
      step("ps_c4", 0, 0, 0, 0, 0, 1, 7, 0, 1);
      step("ps_c5", 0, 0, 0, 0, 0, 1, 7, 0, 1);
      step("ps_stop", 0, 0, 0, 1, 0, 1, 7, 0, 1);
      for (int i = 0; i < 4; i++)
         step("ps_hold", 0, 0, 0, 0, 0, 1, 7, 0, 1);
      step("ps_resume", 0, 0, 1, 0, 0, 1, 7, 0, 1);
      step("ps_phase", 0, 0, 0, 0, 0, 1, 6, 0, 1);
      step("ps_r2", 0, 0, 0, 0, 0, 1, 6, 0, 1);
      step("ps_r3", 0, 0, 0, 0, 0, 1, 5, 0, 1);
      // asynchronous reset in the middle of a run, checked between edges
      step("rr_load", 1, 9, 0, 0, 0, 3, 9, 0, 0);
      step("rr_start", 0, 0, 1, 0, 0, 3, 9, 0, 1);
      step("rr_run", 0, 0, 0, 0, 0, 3, 9, 0, 1);
      #2;
      rst = 1'b1;
      #1;
      check("async_reset", 4'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      step("rr_after", 0, 0, 0, 0, 0, 3, 0, 0, 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
